debug_uart_tx: RTL and testbench

// - Downstream consumer of the microcontroller_top debug_output bus. Samples the
//   bus and queues every new value in a small FIFO.
// - Serialises each queued value as an 8N1-style UART frame on one pin, so a bench
//   or board can log the debug trace without probing the internal bus.
// - Sits beside microcontroller_top in the top level. Shares its clk, reset and enable.

---
 rtl/debug_uart_tx_pkg.sv | 13 +
 rtl/dbg_sync_fifo.sv | 62 ++++++
 rtl/debug_uart_tx.sv | 149 ++++++++++++++
 tb/tb_debug_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_tx_pkg.sv
// Shared constants for the debug UART transmitter: FSM encodings and default framing.
package debug_uart_tx_pkg;

  // Payload width matches the core's operand size.
  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefClksPerBit = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

endpackage

// File: rtl/dbg_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; head word is readable combinationally.
module dbg_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      level
);

  localparam logic [FIFO_AW:0] LevelFull = FIFO_DEPTH[FIFO_AW:0];

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q;
  logic [FIFO_AW-1:0]    rd_ptr_q;
  logic [FIFO_AW:0]      level_q;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (level_q == LevelFull);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full queue still lands when a pop frees the head slot this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (!do_push && do_pop) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// Captures changes on the debug bus into a FIFO and streams each entry out as an 8N1 frame.
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  overflow,
  output logic [FIFO_AW:0]      fifo_level
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] prev_data_q;
  logic                  first_seen_q;
  logic                  overflow_q;
  logic [1:0]            state_q, state_d;
  logic [BaudW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  baud_last;
  logic                  bit_last;

  assign push      = enable & (~first_seen_q | (debug_data != prev_data_q));
  assign baud_last = (baud_cnt_q == BaudW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_cnt_q == BitW'(DATA_WIDTH - 1));
  // Pops happen from idle or on the final stop-bit cycle, giving gap-free back-to-back frames.
  assign pop = enable & ~fifo_empty &
               ((state_q == StIdle) | ((state_q == StStop) & baud_last));

  dbg_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(debug_data),
    .pop      (pop),
    .pop_data (pop_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    if (pop) begin
      state_d    = StStart;
      baud_cnt_d = '0;
      shift_d    = pop_data;
      tx_d       = 1'b0;
    end else begin
      case (state_q)
        StIdle: tx_d = 1'b1;
        StStart: begin
          if (baud_last) begin
            state_d    = StData;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = shift_q[0];
          end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_cnt_d = '0;
            if (bit_last) begin
              state_d = StStop;
              tx_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = shift_q >> 1;
              tx_d      = shift_q[1];
            end
          end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            state_d    = StIdle;
            baud_cnt_d = '0;
            tx_d       = 1'b1;
          end else begin
            baud_cnt_d = baud_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      prev_data_q  <= '0;
      first_seen_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      if (enable) begin
        prev_data_q  <= debug_data;
        first_seen_q <= 1'b1;
      end
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != StIdle);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Self-checking bench for debug_uart_tx: frame tables, directed corner sequences, random soak.
module tb_debug_uart_tx;

  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = (DW + 2) * CPB;

  logic          clk;
  logic          reset_r;
  logic          enable_r;
  logic [DW-1:0] data_r;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [3:0]    fifo_level;

  debug_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .FIFO_AW     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset_r),
    .enable    (enable_r),
    .debug_data(data_r),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a position counter over FRAME cycles plus a queue of bytes.
  int            m_pos = -1;
  logic [DW-1:0] m_cur = '0;
  logic [DW-1:0] m_q[$];
  logic          m_first = 1'b0;
  logic [DW-1:0] m_prev = '0;
  logic          m_ovf = 1'b0;

  int busy_total, busy_rises, peak_level, tx_low_cnt;
  logic prev_busy = 1'b0;

  typedef struct {
    logic [DW-1:0] data;
    logic [9:0]    frame;  // bit i = i-th bit on the line (start first)
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) begin
        $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= DW) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic model_step();
    logic popped;
    if (reset_r) begin
      m_pos = -1;
      m_q.delete();
      m_first = 1'b0;
      m_prev = '0;
      m_ovf = 1'b0;
      return;
    end
    popped = 1'b0;
    if ((m_pos < 0 || m_pos == FRAME - 1) && enable_r && m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      m_pos = 0;
      popped = 1'b1;
    end else if (m_pos == FRAME - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (enable_r && (!m_first || data_r != m_prev)) begin
      if (m_q.size() < DEPTH) m_q.push_back(data_r);
      else m_ovf = 1'b1;
    end
    if (enable_r) begin
      m_prev = data_r;
      m_first = 1'b1;
    end
  endtask

  task automatic reset_stats();
    busy_total = 0;
    busy_rises = 0;
    peak_level = 0;
    tx_low_cnt = 0;
  endtask

  // One clock: advance the model, let the DUT take the edge, compare 1 time unit later.
  task automatic tick();
    logic [6:0] exp_v;
    model_step();
    @(posedge clk);
    #1;
    exp_v = {exp_tx(), (m_pos >= 0), m_ovf, 4'(m_q.size())};
    chk("cycle", int'({tx, busy, overflow, fifo_level}), int'(exp_v));
    if (busy && !prev_busy) busy_rises++;
    if (busy) busy_total++;
    if (!tx) tx_low_cnt++;
    if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
    prev_busy = busy;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic [9:0] exp, input string name);
    logic [FRAME-1:0] smp;
    logic [9:0]       got;
    int               busy_n;
    int               refire;
    busy_n = 0;
    refire = 0;
    data_r = d;
    enable_r = 1'b1;
    tick();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      smp[i] = tx;
      busy_n += int'(busy);
    end
    for (int b = 0; b < 10; b++) got[b] = smp[b*CPB+2];
    chk({name, "_bits"}, int'(got), int'(exp));
    chk({name, "_busy_len"}, busy_n, FRAME);
    tick();
    chk({name, "_end_idle"}, int'(busy), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      refire += int'(busy);
    end
    chk({name, "_no_refire"}, refire, 0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};

    reset_r = 1'b1;
    enable_r = 1'b0;
    data_r = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", int'({tx, busy, overflow, fifo_level}), int'(7'b1000000));
    end
    reset_r = 1'b0;

    for (int v = 0; v < 4; v++) begin
      send_frame(vecs[v].data, vecs[v].frame, $sformatf("frame%0d", v));
    end

    // Back-to-back: three consecutive steps give three gap-free frames.
    reset_stats();
    data_r = 8'h01; tick();
    data_r = 8'h02; tick();
    data_r = 8'h03; tick();
    for (int i = 0; i < 127; i++) tick();
    chk("b2b_busy_total", busy_total, 3 * FRAME);
    chk("b2b_busy_rises", busy_rises, 1);
    chk("b2b_peak_level", peak_level, 2);
    chk("b2b_final_level", int'(fifo_level), 0);

    // Overflow: ten distinct values, one popped at once, eight queued, tenth dropped.
    reset_stats();
    for (int i = 0; i < 10; i++) begin
      data_r = 8'h10 + 8'(i);
      tick();
    end
    for (int i = 0; i < 380; i++) tick();
    chk("ovf_busy_total", busy_total, 9 * FRAME);
    chk("ovf_busy_rises", busy_rises, 1);
    chk("ovf_peak_level", peak_level, DEPTH);
    chk("ovf_sticky", int'(overflow), 1);

    // Enable gating with two entries behind the frame in flight.
    data_r = 8'h21; tick();
    data_r = 8'h22; tick();
    data_r = 8'h23; tick();
    chk("gate_level_queued", int'(fifo_level), 2);
    for (int i = 0; i < 10; i++) tick();
    enable_r = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    reset_stats();
    for (int i = 0; i < 30; i++) tick();
    chk("gate_tx_quiet", tx_low_cnt, 0);
    chk("gate_busy_low", busy_total, 0);
    chk("gate_level_held", int'(fifo_level), 2);
    enable_r = 1'b1;
    reset_stats();
    for (int i = 0; i < 100; i++) tick();
    chk("gate_resume_total", busy_total, 2 * FRAME);
    chk("gate_resume_rises", busy_rises, 1);
    chk("gate_resume_level", int'(fifo_level), 0);

    // Reset during data bit 3 with one entry still queued.
    data_r = 8'h41; tick();
    data_r = 8'h00; tick();
    for (int i = 0; i < 17; i++) tick();
    chk("mid_busy_before", int'(busy), 1);
    reset_r = 1'b1;
    tick();
    chk("mid_reset_out", int'({tx, busy, overflow, fifo_level}), int'(7'b1000000));
    reset_r = 1'b0;
    // 0x00 equals the cleared prev_data, so only the first-sample rule can queue it.
    send_frame(8'h00, 10'b1000000000, "post_reset");

    // Random soak against the model.
    for (int i = 0; i < 4000; i++) begin
      reset_r = ($urandom_range(599) == 0);
      enable_r = ($urandom_range(15) != 0);
      if ($urandom_range(2) == 0) data_r = 8'($urandom_range(7)) * 8'h25;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
